// File: rtl/popo_cpu_pkg.sv
// Shared CPU-side definitions: memory arbiter state encoding, reset
// instruction and wait-counter sizing.
package popo_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2
    } mem_arb_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int WAIT_CNT_MIN_WIDTH = 8;

    // Counter must hold TIMEOUT_CYCLES itself, and never be narrower than 8 bits.
    function automatic int wait_cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w > WAIT_CNT_MIN_WIDTH) ? w : WAIT_CNT_MIN_WIDTH;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for an outstanding memory access; flags the cycle in
// which the count reaches the timeout limit.
module mem_wait_timer
    import popo_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = wait_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CW{1'b0}};
        end else if (count_en && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is reported in the wait cycle whose increment reaches the limit,
    // so exactly TIMEOUT_CYCLES unanswered cycles are tolerated.
    assign expired = count_en && !clear && (count_d >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port
// memory; data wins, one idle cycle separates accesses, stalled accesses time out.
module mem_port_arbiter
    import popo_cpu_pkg::*;
#(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic [INST_ADDR_WIDTH-1:0] PC,
    output logic [INST_WIDTH-1:0]      INST,
    output logic                       inst_mem_hazard,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    input  logic                       cpu_data_mem_write,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ready,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       mem_timeout_err
);

    mem_arb_state_e          state_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [31:0]             mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    timeout_err_q;
    logic [INST_WIDTH-1:0]   inst_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic data_req_s;
    logic idle_s;
    logic busy_s;
    logic inst_done_s;
    logic data_done_s;
    logic load_done_s;
    logic expired_s;

    assign data_req_s  = cpu_data_mem_read | cpu_data_mem_write;
    assign idle_s      = (state_q == IDLE);
    assign busy_s      = (state_q == INST_BUSY) || (state_q == DATA_BUSY);
    assign inst_done_s = (state_q == INST_BUSY) && mem_ready;
    assign data_done_s = (state_q == DATA_BUSY) && mem_ready;
    assign load_done_s = data_done_s && !mem_we_q;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (cpu_clk),
        .rst     (cpu_rst),
        .clear   (idle_s),
        .count_en(busy_s && !mem_ready),
        .expired (expired_s)
    );

    // Arbitration FSM; the memory request is launched from IDLE and held
    // untouched until completion or timeout.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            mem_wdata_q   <= {DATA_WIDTH{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_req_q <= 1'b1;
                    if (data_req_s) begin
                        state_q <= DATA_BUSY;
                        if (cpu_data_mem_write) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= 32'(cpu_data_mem_waddr);
                            mem_wdata_q <= cpu_data_mem_wdata;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= 32'(cpu_data_mem_raddr);
                        end
                    end else begin
                        state_q    <= INST_BUSY;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= 32'(PC);
                    end
                end
                INST_BUSY, DATA_BUSY: begin
                    if (mem_ready || expired_s) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                    if (expired_s) begin
                        timeout_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Completed reads are captured so the CPU keeps seeing them afterwards.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            inst_q  <= INST_WIDTH'(NOP_INST);
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            if (inst_done_s) begin
                inst_q <= INST_WIDTH'(mem_rdata);
            end
            if (load_done_s) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign INST            = inst_done_s ? INST_WIDTH'(mem_rdata) : inst_q;
    assign data_mem_rdata  = load_done_s ? mem_rdata : rdata_q;
    assign inst_mem_hazard = !inst_done_s;
    assign data_mem_hazard = data_req_s && !data_done_s;

    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int          TMO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] PC;
    logic [31:0] INST;
    logic        inst_mem_hazard;
    logic [31:0] cpu_data_mem_raddr;
    logic        cpu_data_mem_read;
    logic [31:0] cpu_data_mem_waddr;
    logic [31:0] cpu_data_mem_wdata;
    logic        cpu_data_mem_write;
    logic [31:0] data_mem_rdata;
    logic        data_mem_hazard;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference model: the one outstanding memory transaction plus the values
    // most recently delivered to each requester.
    bit          m_busy;
    bit          m_is_data;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_waits;
    logic [31:0] m_inst;
    logic [31:0] m_drd;
    bit          m_err;

    mem_port_arbiter #(
        .INST_WIDTH(32), .INST_ADDR_WIDTH(32), .DATA_WIDTH(32),
        .DATA_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .PC(PC), .INST(INST),
        .inst_mem_hazard(inst_mem_hazard),
        .cpu_data_mem_raddr(cpu_data_mem_raddr), .cpu_data_mem_read(cpu_data_mem_read),
        .cpu_data_mem_waddr(cpu_data_mem_waddr), .cpu_data_mem_wdata(cpu_data_mem_wdata),
        .cpu_data_mem_write(cpu_data_mem_write), .data_mem_rdata(data_mem_rdata),
        .data_mem_hazard(data_mem_hazard), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_timeout_err(mem_timeout_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        if (cpu_rst) begin
            m_busy = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
            m_inst = NOP; m_drd = 32'h0; m_err = 1'b0; m_waits = 0;
        end else if (!m_busy) begin
            m_busy    = 1'b1;
            m_waits   = 0;
            m_is_data = cpu_data_mem_read | cpu_data_mem_write;
            if (cpu_data_mem_write) begin
                m_we = 1'b1; m_addr = cpu_data_mem_waddr; m_wdata = cpu_data_mem_wdata;
            end else if (cpu_data_mem_read) begin
                m_we = 1'b0; m_addr = cpu_data_mem_raddr;
            end else begin
                m_we = 1'b0; m_addr = PC;
            end
        end else if (mem_ready) begin
            if (!m_is_data) m_inst = mem_rdata;
            else if (!m_we) m_drd = mem_rdata;
            m_busy = 1'b0;
        end else begin
            m_waits++;
            if (m_waits >= TMO) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b0; PC = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        cpu_data_mem_read = 1'b0; cpu_data_mem_write = 1'b0;
        cpu_data_mem_raddr = 32'h0; cpu_data_mem_waddr = 32'h0; cpu_data_mem_wdata = 32'h0;
        #1;
        cpu_rst = 1'b1;
        model_edge();
        tick();
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        total++; if (INST !== NOP) begin bad++; $display("FAIL reset_inst: got %h want %h", INST, NOP); end
        total++; if (data_mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_drdata: got %h want 0", data_mem_rdata); end
        total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", mem_timeout_err); end
        total++; if (inst_mem_hazard !== 1'b1) begin bad++; $display("FAIL reset_inst_haz: got %b want 1", inst_mem_hazard); end
        total++; if (data_mem_hazard !== 1'b0) begin bad++; $display("FAIL reset_data_haz: got %b want 0", data_mem_hazard); end
        cpu_rst = 1'b0;
    endtask

    task automatic test_fetch_basic();
        PC = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        #2;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_idle_req: got %b want 0", mem_req); end
        total++; if (inst_mem_hazard !== 1'b1) begin bad++; $display("FAIL fetch_idle_haz: got %b want 1", inst_mem_hazard); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            bad++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b want req=1 addr=100 we=0", mem_req, mem_addr, mem_we);
        end
        #2;
        total++; if (INST !== 32'h0050_0093) begin bad++; $display("FAIL fetch_inst: got %h want 00500093", INST); end
        total++; if (inst_mem_hazard !== 1'b0) begin bad++; $display("FAIL fetch_done_haz: got %b want 0", inst_mem_hazard); end
        tick();
        mem_rdata = 32'hFFFF_FFFF;
        #2;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_after_req: got %b want 0", mem_req); end
        total++; if (INST !== 32'h0050_0093) begin bad++; $display("FAIL fetch_inst_hold: got %h want 00500093", INST); end
        total++; if (inst_mem_hazard !== 1'b1) begin bad++; $display("FAIL fetch_after_haz: got %b want 1", inst_mem_hazard); end
    endtask

    task automatic test_load_priority();
        int haz_cnt;
        haz_cnt = 0;
        cpu_data_mem_read = 1'b1; cpu_data_mem_raddr = 32'h2000; PC = 32'h300;
        for (int c = 0; c < 5; c++) begin
            mem_ready = (c == 4);
            mem_rdata = (c == 4) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            if (c == 1) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin
                    bad++; $display("FAIL load_issue: got req=%b addr=%h we=%b want req=1 addr=2000 we=0", mem_req, mem_addr, mem_we);
                end
            end
            #2;
            if (data_mem_hazard === 1'b1) haz_cnt++;
            if (c == 4) begin
                total++; if (data_mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", data_mem_rdata); end
                total++; if (inst_mem_hazard !== 1'b1) begin bad++; $display("FAIL load_inst_haz: got %b want 1", inst_mem_hazard); end
            end
            tick();
        end
        cpu_data_mem_read = 1'b0; mem_ready = 1'b0;
        total++; if (haz_cnt !== 4) begin bad++; $display("FAIL load_haz_cycles: got %0d want 4", haz_cnt); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL load_gap_req: got %b want 0", mem_req); end
        #2;
        total++; if (data_mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata_hold: got %h want deadbeef", data_mem_rdata); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            bad++; $display("FAIL load_then_fetch: got req=%b addr=%h want req=1 addr=300", mem_req, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0000_0093;
        #2;
        total++; if (INST !== 32'h0000_0093) begin bad++; $display("FAIL load_then_fetch_inst: got %h want 00000093", INST); end
        tick();
    endtask

    task automatic test_store_over_read();
        mem_ready = 1'b0;
        cpu_data_mem_read = 1'b1; cpu_data_mem_write = 1'b1;
        cpu_data_mem_raddr = 32'h80; cpu_data_mem_waddr = 32'h40; cpu_data_mem_wdata = 32'h1234_5678;
        tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234_5678) begin
            bad++; $display("FAIL store_issue: got we=%b addr=%h wdata=%h want we=1 addr=40 wdata=12345678", mem_we, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #2;
        total++; if (data_mem_hazard !== 1'b0) begin bad++; $display("FAIL store_done_haz: got %b want 0", data_mem_hazard); end
        total++; if (data_mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_rdata_kept: got %h want deadbeef", data_mem_rdata); end
        tick();
        cpu_data_mem_read = 1'b0; cpu_data_mem_write = 1'b0; mem_ready = 1'b0;
        #2;
        total++; if (data_mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_rdata_after: got %h want deadbeef", data_mem_rdata); end
    endtask

    task automatic test_timeout();
        int busy;
        busy = 0;
        cpu_data_mem_read = 1'b1; cpu_data_mem_raddr = 32'h500; mem_ready = 1'b0;
        total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_err_before: got %b want 0", mem_timeout_err); end
        tick();
        while (mem_req === 1'b1 && busy < 20) begin
            busy++;
            #2;
            total++; if (data_mem_hazard !== 1'b1) begin bad++; $display("FAIL tmo_wait_haz: got %b want 1", data_mem_hazard); end
            tick();
        end
        total++; if (busy !== TMO) begin bad++; $display("FAIL tmo_busy_cycles: got %0d want %0d", busy, TMO); end
        total++; if (mem_timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err_set: got %b want 1", mem_timeout_err); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL tmo_abort_req: got %b want 0", mem_req); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            bad++; $display("FAIL tmo_reissue: got req=%b addr=%h want req=1 addr=500", mem_req, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        #2;
        total++; if (data_mem_rdata !== 32'h1111_2222) begin bad++; $display("FAIL tmo_retry_rdata: got %h want 11112222", data_mem_rdata); end
        tick();
        cpu_data_mem_read = 1'b0; mem_ready = 1'b0;
        total++; if (mem_timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky: got %b want 1", mem_timeout_err); end
    endtask

    task automatic test_reset_mid_busy();
        cpu_data_mem_read = 1'b1; cpu_data_mem_raddr = 32'h600; mem_ready = 1'b0;
        tick();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstbusy_req_before: got %b want 1", mem_req); end
        #2;
        cpu_rst = 1'b1;
        #1;
        model_edge();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstbusy_async_req: got %b want 0", mem_req); end
        total++; if (INST !== NOP) begin bad++; $display("FAIL rstbusy_inst: got %h want %h", INST, NOP); end
        total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL rstbusy_err: got %b want 0", mem_timeout_err); end
        tick();
        cpu_rst = 1'b0; cpu_data_mem_read = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        #2;
        total++; if (INST !== NOP) begin bad++; $display("FAIL rstbusy_stale_inst: got %h want %h", INST, NOP); end
        total++; if (data_mem_rdata !== 32'h0) begin bad++; $display("FAIL rstbusy_stale_drdata: got %h want 0", data_mem_rdata); end
        total++; if (inst_mem_hazard !== 1'b1) begin bad++; $display("FAIL rstbusy_stale_haz: got %b want 1", inst_mem_hazard); end
        tick();
        mem_ready = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            bad++; $display("FAIL rstbusy_next_fetch: got req=%b addr=%h want req=1 addr=300", mem_req, mem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc_r;
        logic [31:0] exp_inst;
        logic [31:0] exp_drd;
        bit          idone;
        bit          ddone;
        bit          exp_dh;
        bit          drop;
        pc_r = 32'h300;
        for (int n = 0; n < 400; n++) begin
            total++; if (mem_req !== m_busy) begin bad++; $display("FAIL rnd_req n=%0d: got %b want %b", n, mem_req, m_busy); end
            if (m_busy) begin
                total++; if (mem_addr !== m_addr) begin bad++; $display("FAIL rnd_addr n=%0d: got %h want %h", n, mem_addr, m_addr); end
                total++; if (mem_we !== m_we) begin bad++; $display("FAIL rnd_we n=%0d: got %b want %b", n, mem_we, m_we); end
                if (m_we) begin
                    total++; if (mem_wdata !== m_wdata) begin bad++; $display("FAIL rnd_wdata n=%0d: got %h want %h", n, mem_wdata, m_wdata); end
                end
            end
            total++; if (mem_timeout_err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d: got %b want %b", n, mem_timeout_err, m_err); end

            if (!(cpu_data_mem_read | cpu_data_mem_write) && $urandom_range(3) == 0) begin
                cpu_data_mem_raddr = $urandom();
                cpu_data_mem_waddr = $urandom();
                cpu_data_mem_wdata = $urandom();
                case ($urandom_range(2))
                    0:       begin cpu_data_mem_read = 1'b1; cpu_data_mem_write = 1'b0; end
                    1:       begin cpu_data_mem_read = 1'b0; cpu_data_mem_write = 1'b1; end
                    default: begin cpu_data_mem_read = 1'b1; cpu_data_mem_write = 1'b1; end
                endcase
            end
            PC        = pc_r;
            mem_ready = ($urandom_range(4) < 2);
            mem_rdata = $urandom();
            #2;

            idone    = m_busy && !m_is_data && mem_ready;
            ddone    = m_busy && m_is_data && mem_ready;
            exp_inst = idone ? mem_rdata : m_inst;
            exp_drd  = (ddone && !m_we) ? mem_rdata : m_drd;
            exp_dh   = (cpu_data_mem_read | cpu_data_mem_write) && !ddone;
            total++; if (INST !== exp_inst) begin bad++; $display("FAIL rnd_inst n=%0d: got %h want %h", n, INST, exp_inst); end
            total++; if (inst_mem_hazard !== !idone) begin bad++; $display("FAIL rnd_inst_haz n=%0d: got %b want %b", n, inst_mem_hazard, !idone); end
            total++; if (data_mem_hazard !== exp_dh) begin bad++; $display("FAIL rnd_data_haz n=%0d: got %b want %b", n, data_mem_hazard, exp_dh); end
            total++; if (data_mem_rdata !== exp_drd) begin bad++; $display("FAIL rnd_drdata n=%0d: got %h want %h", n, data_mem_rdata, exp_drd); end

            if (idone) pc_r = pc_r + 32'd4;
            drop = ddone;
            tick();
            if (drop) begin
                cpu_data_mem_read  = 1'b0;
                cpu_data_mem_write = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_load_priority();
        test_store_over_read();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: INST_WIDTH, default 32, instruction width; INST_ADDR_WIDTH, default 32, fetch address width; DATA_WIDTH, default 32, data word width; DATA_ADDR_WIDTH, default 32, data address width; TIMEOUT_CYCLES, default 255, maximum wait for mem_ready.
REQ-002 cpu_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 cpu_rst  in  1  asynchronous, active-high reset.
REQ-004 PC  in  INST_ADDR_WIDTH  fetch address; a fetch is requested every cycle.
REQ-005 INST  out  INST_WIDTH  fetched instruction.
REQ-006 inst_mem_hazard  out  1  fetch not completing this cycle; stall PC/IF.
REQ-007 cpu_data_mem_raddr  in  DATA_ADDR_WIDTH  load address.
REQ-008 cpu_data_mem_read  in  1  load request.
REQ-009 cpu_data_mem_waddr  in  DATA_ADDR_WIDTH  store address.
REQ-010 cpu_data_mem_wdata  in  DATA_WIDTH  store data.
REQ-011 cpu_data_mem_write  in  1  store request.
REQ-012 data_mem_rdata  out  DATA_WIDTH  load data.
REQ-013 data_mem_hazard  out  1  data access pending and not completing this cycle.
REQ-014 mem_req, mem_we  out  1 each  registered request and write strobe to the single-port memory.
REQ-015 mem_addr  out  32; mem_wdata  out  DATA_WIDTH  registered request address and store data.
REQ-016 mem_ready  in  1  memory completes the current request this cycle; mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1.
REQ-017 mem_timeout_err  out  1  sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, INST_BUSY, DATA_BUSY; reset state IDLE.
REQ-019 In IDLE, data_req=(read|write) SHALL win over the fetch: with data_req, go to DATA_BUSY; otherwise go to INST_BUSY.
REQ-020 On leaving IDLE, mem_req=1 and mem_addr/mem_we/mem_wdata SHALL be registered: waddr+wdata with mem_we=1 if write=1, else raddr with mem_we=0. Write wins if read and write are both high.
REQ-021 For INST_BUSY, mem_addr SHALL be PC and mem_we SHALL be 0.
REQ-022 While in a BUSY state, mem_req/mem_addr/mem_we/mem_wdata SHALL be held stable until mem_ready=1.
REQ-023 The cycle with mem_ready=1 in a BUSY state SHALL complete the access. The FSM returns to IDLE and mem_req deasserts on the next edge. One IDLE cycle always separates accesses.
REQ-024 Fetch completion SHALL drive INST=mem_rdata combinationally in that cycle, register it, and hold it afterwards.
REQ-025 Load completion SHALL do the same for data_mem_rdata. Store completion SHALL leave data_mem_rdata unchanged.
REQ-026 inst_mem_hazard SHALL be 1 except in the INST_BUSY cycle where mem_ready=1.
REQ-027 data_mem_hazard SHALL be data_req AND NOT (DATA_BUSY AND mem_ready).
REQ-028 Requesters SHALL hold address/data/strobes stable while their hazard is 1. The arbiter does not re-sample them in BUSY.
REQ-029 Minimum latency SHALL be 2 cycles from IDLE-with-request to completion: request registered, then mem_ready on the next cycle at the earliest.
REQ-030 mem_ready while in IDLE SHALL be ignored.
REQ-031 A wait counter (8 bits minimum, saturating) SHALL clear on entering BUSY and increment each BUSY cycle without mem_ready.
REQ-032 When the wait counter reaches TIMEOUT_CYCLES, the access SHALL be aborted: return to IDLE, mem_req=0, and mem_timeout_err=1 until reset. The aborted requester's hazard stays 1, so it retries.

Reset
REQ-033 cpu_rst=1 SHALL immediately force: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, INST=32'h00000013 (NOP), data_mem_rdata=0, wait counter=0, mem_timeout_err=0.
REQ-034 Reset during BUSY SHALL abandon the access. No completion is reported and mem_ready is ignored until the next request is issued.

Structure
REQ-035 The FSM state encoding and the NOP constant 32'h00000013 SHALL live in the shared package popo_cpu_pkg.
REQ-036 The wait counter SHALL be a sub-module mem_wait_timer with ports clear, count_en, and expired.

Verification
REQ-037 Idle data path, PC=0x100, mem_ready=1 every cycle -> mem_req with mem_addr=0x100 next cycle; INST=mem_rdata=0x00500093 one cycle later; hazard low only in that cycle.
REQ-038 Load raddr=0x2000 and fetch pending simultaneously, mem_ready delayed 3 cycles, mem_rdata=0xDEADBEEF -> data issued first; data_mem_hazard=1 for 4 cycles; data_mem_rdata=0xDEADBEEF; fetch issued after one IDLE cycle.
REQ-039 Store waddr=0x40, wdata=0x12345678, with read=1 also asserted -> mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; data_mem_rdata unchanged.
REQ-040 TIMEOUT_CYCLES=4, mem_ready held 0 -> abort after 4 wait cycles; mem_timeout_err=1 and sticky; the same request is re-issued.
REQ-041 Assert cpu_rst mid-DATA_BUSY -> mem_req=0 asynchronously; INST=0x00000013; a stale mem_ready pulse after release produces no completion.
